// File: rtl/coin_dispenser_if.sv
// coin_dispenser_if -- refund request / coin-line bundle for coin_dispenser.
//
// Signals:
//   start, amount   request side (driven by the requester)
//   abort           cancel request (COIN_DISPENSER_ABORT_EN builds only)
//   busy            refund in progress
//   D, N            one-cycle dime / nickel pulses
//   done, err       one-cycle completion pulse, err marks a rejected or
//                   aborted refund
//
// Modports: master = requester / coin receiver, slave = coin_dispenser.
interface coin_dispenser_if #(
  parameter int AMT_W = 8
);
  logic             start;
  logic [AMT_W-1:0] amount;
  logic             busy;
  logic             D;
  logic             N;
  logic             done;
  logic             err;
`ifdef COIN_DISPENSER_ABORT_EN
  logic             abort;
`endif

  modport master (
`ifdef COIN_DISPENSER_ABORT_EN
    output abort,
`endif
    output start, amount,
    input  busy, D, N, done, err
  );

  modport slave (
`ifdef COIN_DISPENSER_ABORT_EN
    input  abort,
`endif
    input  start, amount,
    output busy, D, N, done, err
  );
endinterface

// File: rtl/coin_dispenser.sv
// coin_dispenser -- change-return transmitter.
//
// Takes a refund amount in cents and emits a serial stream of one-cycle
// dime (D) and nickel (N) pulses, dimes first, with GAP idle cycles after
// every coin. Amounts that are not a multiple of 5 are rejected with no
// coins and a done+err pulse.
//
// Parameters:
//   AMT_W  width of the refund amount
//   GAP    idle cycles after each coin pulse (0..15)
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous, active-high
//   bus        coin_dispenser_if.slave (start/amount/abort in,
//              busy/D/N/done/err out, all outputs registered)
//   state_dbg  current FSM state (0 IDLE, 1 ISSUE, 2 GAPWAIT, 3 DONE)
//
// Handshake: a refund is accepted on the rising edge where the FSM is IDLE
// and start=1; amount is captured on that edge and busy rises with it.
// start is ignored while busy=1. busy stays high through the done cycle and
// falls on the following edge; the next request is taken from IDLE.
//
// Optional feature (macro COIN_DISPENSER_ABORT_EN): adds bus.abort. An abort
// sampled while a refund is in ISSUE or GAPWAIT ends it with done=err=1 on
// that edge. abort has no effect in IDLE, so start wins there.
module coin_dispenser #(
  parameter int AMT_W = 8,
  parameter int GAP   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  coin_dispenser_if.slave       bus,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    GAPWAIT = 2'd2,
    DONE_ST = 2'd3
  } state_t;

  // GAPWAIT is entered on the coin edge and left after GAP edges, so the
  // counter starts at GAP-1 and the exit happens when it reads zero.
  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam logic [AMT_W-1:0] DIME   = AMT_W'(10);
  localparam logic [AMT_W-1:0] NICKEL = AMT_W'(5);

  state_t           state, state_n;
  logic [AMT_W-1:0] rem, rem_n;
  logic             bad, bad_n;
  logic [3:0]       gap_cnt, gap_cnt_n;
  logic             busy_n, d_n, n_n, done_n, err_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rem      <= '0;
      bad      <= 1'b0;
      gap_cnt  <= 4'd0;
      bus.busy <= 1'b0;
      bus.D    <= 1'b0;
      bus.N    <= 1'b0;
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
    end else begin
      state    <= state_n;
      rem      <= rem_n;
      bad      <= bad_n;
      gap_cnt  <= gap_cnt_n;
      bus.busy <= busy_n;
      bus.D    <= d_n;
      bus.N    <= n_n;
      bus.done <= done_n;
      bus.err  <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    rem_n     = rem;
    bad_n     = bad;
    gap_cnt_n = gap_cnt;
    busy_n    = bus.busy;
    d_n       = 1'b0;
    n_n       = 1'b0;
    done_n    = 1'b0;
    err_n     = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = ISSUE;
          rem_n   = bus.amount;
          bad_n   = (bus.amount % NICKEL) != '0;
          busy_n  = 1'b1;
        end
      end

      ISSUE: begin
        if (bad || rem == '0) begin
          done_n  = 1'b1;
          err_n   = bad;
          state_n = DONE_ST;
        end else begin
          // rem is a nonzero multiple of 5 here, so below 10 means exactly 5.
          if (rem >= DIME) begin
            d_n   = 1'b1;
            rem_n = rem - DIME;
          end else begin
            n_n   = 1'b1;
            rem_n = rem - NICKEL;
          end
          if (GAP == 0) begin
            state_n = ISSUE;
          end else begin
            state_n   = GAPWAIT;
            gap_cnt_n = GAP_LOAD;
          end
        end
      end

      GAPWAIT: begin
        if (gap_cnt == 4'd0) begin
          state_n = ISSUE;
        end else begin
          gap_cnt_n = gap_cnt - 4'd1;
        end
      end

      DONE_ST: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        bad_n   = 1'b0;
      end

      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase

`ifdef COIN_DISPENSER_ABORT_EN
    // A pulse raised on an earlier edge already ends by itself; here only
    // the coin that would start on this edge is suppressed.
    if (bus.abort && (state == ISSUE || state == GAPWAIT)) begin
      d_n     = 1'b0;
      n_n     = 1'b0;
      done_n  = 1'b1;
      err_n   = 1'b1;
      state_n = DONE_ST;
    end
`endif
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_coin_dispenser.sv
// tb_coin_dispenser -- self-checking bench for coin_dispenser.
// Each refund's expected coin/done events are pushed to exp_q from a small
// greedy model before start is driven, then popped as the DUT emits them.
// Event word: {edge index[15:0], err, done, N, D}.
module tb_coin_dispenser;
  localparam int AMT_W = 8;
  localparam int GAP   = 1;

  logic       clk;
  logic       reset;
  logic [1:0] state_dbg;
  int         total;
  int         bad;
  logic [19:0] exp_q[$];

  coin_dispenser_if #(.AMT_W(AMT_W)) bus ();

  coin_dispenser #(.AMT_W(AMT_W), .GAP(GAP)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one refund and checks every emitted event against the model.
  // abort_at: edge at which abort is sampled (-1 none, 0 together with start).
  // hold_start: keep start high through the refund, then expect re-accept.
  task automatic run_refund(input logic [AMT_W-1:0] amt, input int abort_at,
                            input bit hold_start);
    logic [19:0] obs;
    logic [19:0] exp;
    logic [15:0] t16;
    int nd, nn, t, done_t, tally, exp_tally, k, done_k;
    bit seen_done, finished;

    exp_q.delete();
    exp_tally = 0;
    if ((amt % 5) != 0) begin
      exp_q.push_back({16'd1, 4'b1100});
    end else begin
      nd = amt / 10;
      nn = (amt % 10) / 5;
      done_t = 1 + (nd + nn) * (GAP + 1);
      for (int i = 0; i < nd + nn; i++) begin
        t = 1 + i * (GAP + 1);
        if (abort_at > 0 && t >= abort_at) break;
        t16 = t[15:0];
        exp_q.push_back({t16, 2'b00, (i >= nd), (i < nd)});
        exp_tally += (i < nd) ? 10 : 5;
      end
      if (abort_at > 0 && abort_at <= done_t) begin
        t16 = abort_at[15:0];
        exp_q.push_back({t16, 4'b1100});
      end else begin
        t16 = done_t[15:0];
        exp_q.push_back({t16, 4'b0100});
      end
    end

    @(negedge clk);
    bus.start  = 1'b1;
    bus.amount = amt;
`ifdef COIN_DISPENSER_ABORT_EN
    bus.abort  = (abort_at == 0);
`endif
    tally = 0;
    seen_done = 1'b0;
    finished = 1'b0;
    done_k = 0;
    k = 0;
    while (!finished && k < 300) begin
      @(negedge clk);
      if (k == 0) begin
        total++;
        if (bus.busy !== 1'b1) begin
          bad++;
          $display("FAIL busy_on_accept amt=%0d got=%b want=1", amt, bus.busy);
        end
        if (!hold_start) bus.start = 1'b0;
      end
`ifdef COIN_DISPENSER_ABORT_EN
      bus.abort = (abort_at == k + 1);
`endif
      if (seen_done && k == done_k + 1) begin
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
          bad++;
          $display("FAIL busy_fall amt=%0d k=%0d busy=%b done=%b want 0/0",
                   amt, k, bus.busy, bus.done);
        end
        finished = 1'b1;
      end else if (bus.D || bus.N || bus.done || bus.err) begin
        t16 = k[15:0];
        obs = {t16, bus.err, bus.done, bus.N, bus.D};
        if (bus.D) tally += 10;
        if (bus.N) tally += 5;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event amt=%0d got=%h want=none", amt, obs);
        end else begin
          exp = exp_q.pop_front();
          if (obs !== exp) begin
            bad++;
            $display("FAIL event amt=%0d got=%h want=%h", amt, obs, exp);
          end
        end
        if (bus.D && bus.N) begin
          bad++;
          $display("FAIL d_and_n amt=%0d k=%0d got=11 want=not both", amt, k);
        end
        if (bus.done) begin
          seen_done = 1'b1;
          done_k = k;
        end
      end
      k++;
    end

    total++;
    if (!finished) begin
      bad++;
      $display("FAIL timeout amt=%0d got=no completion want=done then busy low", amt);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_events amt=%0d got=%0d left want=0", amt, exp_q.size());
    end
    total++;
    if (tally != exp_tally) begin
      bad++;
      $display("FAIL tally amt=%0d got=%0d want=%0d", amt, tally, exp_tally);
    end

    if (hold_start) begin
      @(negedge clk);
      total++;
      if (bus.busy !== 1'b1) begin
        bad++;
        $display("FAIL reaccept amt=%0d got busy=%b want=1", amt, bus.busy);
      end
      bus.start = 1'b0;
      for (int j = 0; j < 20 && bus.busy; j++) @(negedge clk);
      total++;
      if (bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL reaccept_end amt=%0d got busy=%b want=0", amt, bus.busy);
      end
    end
  endtask

  task automatic test_reset;
    // start a refund so the reset has live state to clear
    @(negedge clk);
    bus.start  = 1'b1;
    bus.amount = 8'd25;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({bus.busy, bus.D, bus.N, bus.done, bus.err} !== 5'b0 || state_dbg !== 2'd0) begin
      bad++;
      $display("FAIL reset_async got=%b st=%0d want=00000 st=0",
               {bus.busy, bus.D, bus.N, bus.done, bus.err}, state_dbg);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({bus.busy, bus.D, bus.N, bus.done, bus.err} !== 5'b0 || state_dbg !== 2'd0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%b st=%0d want=00000 st=0", i,
                 {bus.busy, bus.D, bus.N, bus.done, bus.err}, state_dbg);
      end
    end
  endtask

  task automatic test_greedy;
    run_refund(8'd25, -1, 1'b0);
  endtask

  task automatic test_boundary;
    run_refund(8'd0, -1, 1'b0);
    run_refund(8'd250, -1, 1'b0);
    run_refund(8'd5, -1, 1'b0);
  endtask

  task automatic test_invalid;
    run_refund(8'd17, -1, 1'b1);
  endtask

  task automatic test_mid_reset;
    int dimes;
    dimes = 0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.amount = 8'd40;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 20 && dimes < 2; i++) begin
      @(negedge clk);
      if (bus.D) dimes++;
    end
    total++;
    if (dimes != 2) begin
      bad++;
      $display("FAIL mid_reset_dimes got=%0d want=2", dimes);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({bus.busy, bus.D, bus.N, bus.done, bus.err} !== 5'b0) begin
      bad++;
      $display("FAIL mid_reset_clear got=%b want=00000",
               {bus.busy, bus.D, bus.N, bus.done, bus.err});
    end
    @(negedge clk);
    reset = 1'b0;
    run_refund(8'd10, -1, 1'b0);
  endtask

  task automatic test_random;
    logic [AMT_W-1:0] a;
    for (int i = 0; i < 6; i++) begin
      if (i % 3 == 2) a = AMT_W'($urandom_range(1, 250));
      else            a = AMT_W'(5 * $urandom_range(0, 50));
      run_refund(a, -1, 1'b0);
    end
  endtask

  task automatic test_back_to_back;
    run_refund(8'd15, -1, 1'b0);
    run_refund(8'd30, -1, 1'b0);
  endtask

`ifdef COIN_DISPENSER_ABORT_EN
  task automatic test_abort;
    run_refund(8'd30, 2, 1'b0);
    run_refund(8'd20, 0, 1'b0);
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.amount = '0;
`ifdef COIN_DISPENSER_ABORT_EN
    bus.abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_greedy();
    test_boundary();
    test_invalid();
    test_mid_reset();
    test_back_to_back();
    test_random();
`ifdef COIN_DISPENSER_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
